// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit pipelined processor.
//   ADDR_W / INSTR_W : PC and instruction widths
//   RESET_PC         : PC value after reset
//   OP_*             : opcode field encodings (instr[15:12])
//   fetch_state_e    : fetch stage run/halt state
package proc_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation for the fetch stage (purely combinational).
//   base_i       : PC+2 of the instruction currently in ID
//   b_jmp_i      : 1 = branch (8-bit offset), 0 = jump (12-bit offset)
//   br_offset_i  : signed branch offset in instruction words
//   jmp_offset_i : signed jump offset in instruction words
//   target_o     : base + 2*offset, modulo 2^ADDR_W
module pc_target_calc #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic              b_jmp_i,
  input  logic [7:0]        br_offset_i,
  input  logic [11:0]       jmp_offset_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] br_byte_off;
  logic [ADDR_W-1:0] jmp_byte_off;

  // Offsets are in words; sign-extend and append a zero to get a byte offset.
  assign br_byte_off  = {{(ADDR_W-9){br_offset_i[7]}}, br_offset_i, 1'b0};
  assign jmp_byte_off = {{(ADDR_W-13){jmp_offset_i[11]}}, jmp_offset_i, 1'b0};

  assign target_o = base_i + (b_jmp_i ? br_byte_off : jmp_byte_off);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// loads the IF/ID register, freezes on halt and counts fetched instructions.
//   clk, reset         : clock and synchronous active-high reset
//   stall              : hold PC and IF/ID
//   pc_op, b_jmp       : redirect request and its type (branch/jump)
//   halt, if_flush     : halt request, invalidate the entry loaded this cycle
//   br_offset/jmp_offset : signed word offsets for the redirect target
//   imem_addr/imem_data  : combinational instruction-memory port
//   if_id_*            : IF/ID pipeline register
//   halted, fetch_count: status outputs
//
// state  | meaning
// RUN    | fetching; halt > stall > redirect > sequential fetch
// HALTED | everything frozen, IF/ID invalid; left only by reset
module fetch_unit #(
  parameter int unsigned       ADDR_W   = proc_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = proc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_op,
  input  logic               b_jmp,
  input  logic               halt,
  input  logic               if_flush,
  input  logic [7:0]         br_offset,
  input  logic [11:0]        jmp_offset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import proc_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  target;

  assign pc_inc = pc_q + ADDR_W'(2);

  // Redirects are relative to the instruction sitting in ID.
  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .base_i       (pc_plus2_q),
    .b_jmp_i      (b_jmp),
    .br_offset_i  (br_offset),
    .jmp_offset_i (jmp_offset),
    .target_o     (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    case (state_q)
      RUN: begin
        if (halt) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else if (stall) begin
          // Hold everything: the instruction in ID has not resolved yet.
        end else if (pc_op) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else begin
          pc_d       = pc_inc;
          instr_d    = imem_data;
          pc_plus2_d = pc_inc;
          valid_d    = ~if_flush;
          if (!if_flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pc_plus2_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALTED);
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, pc_op, b_jmp, halt, if_flush;
  logic [7:0]  br_offset;
  logic [11:0] jmp_offset;
  logic [15:0] imem_addr, imem_data, if_id_instr, if_id_pc_plus2, fetch_count;
  logic        if_id_valid, halted;

  // Second instance with a narrow counter so saturation is reachable quickly.
  logic [15:0] s_addr, s_data, s_instr, s_pp2;
  logic        s_valid, s_halted;
  logic [3:0]  s_cnt;

  function automatic logic [15:0] imem_f(input logic [15:0] a);
    return ((a >> 1) + 16'd1) * 16'h1111;
  endfunction

  assign imem_data = imem_f(imem_addr);
  assign s_data    = imem_f(s_addr);

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp),
    .halt(halt), .if_flush(if_flush), .br_offset(br_offset), .jmp_offset(jmp_offset),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_id_instr(if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp),
    .halt(halt), .if_flush(if_flush), .br_offset(br_offset), .jmp_offset(jmp_offset),
    .imem_addr(s_addr), .imem_data(s_data), .if_id_instr(s_instr),
    .if_id_pc_plus2(s_pp2), .if_id_valid(s_valid), .halted(s_halted),
    .fetch_count(s_cnt)
  );

  int n_chk;
  int n_fail;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_pp2, m_cnt;
  logic [3:0]  m_scnt;
  logic        m_valid, m_halted;

  // Drive one cycle of inputs, advance the model by the architectural rules,
  // then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic st, input logic po, input logic bj,
                      input logic hl, input logic fl, input logic [7:0] bo,
                      input logic [11:0] jo);
    int t;
    reset = r; stall = st; pc_op = po; b_jmp = bj; halt = hl; if_flush = fl;
    br_offset = bo; jmp_offset = jo;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0; m_pp2 = 16'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_cnt = 16'h0; m_scnt = 4'h0;
    end else if (!m_halted) begin
      if (hl) begin
        m_valid = 1'b0; m_halted = 1'b1;
      end else if (st) begin
      end else if (po) begin
        t = int'(m_pp2) + 2 * (bj ? int'($signed(bo)) : int'($signed(jo)));
        m_pc = t[15:0];
        m_valid = 1'b0;
      end else begin
        m_instr = imem_f(m_pc);
        m_pc    = m_pc + 16'd2;
        m_pp2   = m_pc;
        m_valid = !fl;
        if (!fl) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'h00, 12'h000);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    n_chk++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h exp 0000", imem_addr); end
    n_chk++; if (if_id_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h exp 0000", if_id_instr); end
    n_chk++; if (if_id_pc_plus2 !== 16'h0000) begin n_fail++; $display("FAIL reset_pp2: got %h exp 0000", if_id_pc_plus2); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
    n_chk++; if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h exp 0000", fetch_count); end
  endtask

  task automatic test_fetch();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    for (int k = 1; k <= 4; k++) begin
      fetch_n(1);
      n_chk++; if (imem_addr !== 16'(2 * k)) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %h exp %h", k, imem_addr, 16'(2 * k)); end
      n_chk++; if (if_id_instr !== 16'(k * 16'h1111)) begin n_fail++; $display("FAIL fetch_instr[%0d]: got %h exp %h", k, if_id_instr, 16'(k * 16'h1111)); end
      n_chk++; if (if_id_pc_plus2 !== 16'(2 * k)) begin n_fail++; $display("FAIL fetch_pp2[%0d]: got %h exp %h", k, if_id_pc_plus2, 16'(2 * k)); end
      n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d]: got %b exp 1", k, if_id_valid); end
    end
    n_chk++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL fetch_count: got %h exp 0004", fetch_count); end
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(8);
    n_chk++; if (if_id_pc_plus2 !== 16'h0010) begin n_fail++; $display("FAIL redir_base: got %h exp 0010", if_id_pc_plus2); end
    step(0, 0, 1, 1, 0, 0, 8'hFC, 12'h000);
    n_chk++; if (imem_addr !== 16'h0008) begin n_fail++; $display("FAIL redir_branch: got %h exp 0008", imem_addr); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b exp 0", if_id_valid); end
    step(0, 0, 1, 0, 0, 0, 8'h00, 12'h010);
    n_chk++; if (imem_addr !== 16'h0030) begin n_fail++; $display("FAIL redir_jump: got %h exp 0030", imem_addr); end
    fetch_n(1);
    n_chk++; if (if_id_instr !== imem_f(16'h0030)) begin n_fail++; $display("FAIL redir_instr: got %h exp %h", if_id_instr, imem_f(16'h0030)); end
    n_chk++; if (if_id_pc_plus2 !== 16'h0032) begin n_fail++; $display("FAIL redir_pp2: got %h exp 0032", if_id_pc_plus2); end
    n_chk++; if (fetch_count !== 16'd9) begin n_fail++; $display("FAIL redir_count: got %h exp 0009", fetch_count); end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, i[0], 0, 1, 8'h05, 12'h7F0);
      n_chk++; if (imem_addr !== 16'h0006) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h exp 0006", i, imem_addr); end
      n_chk++; if (if_id_instr !== 16'h3333 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ifid[%0d]: got %h/%b exp 3333/1", i, if_id_instr, if_id_valid); end
      n_chk++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL stall_count[%0d]: got %h exp 0003", i, fetch_count); end
    end
    fetch_n(1);
    n_chk++; if (if_id_instr !== 16'h4444 || imem_addr !== 16'h0008) begin n_fail++; $display("FAIL stall_resume: got %h@%h exp 4444@0008", if_id_instr, imem_addr); end
  endtask

  task automatic test_flush();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(2);
    step(0, 0, 0, 0, 0, 1, 8'h00, 12'h000);
    n_chk++; if (imem_addr !== 16'h0006) begin n_fail++; $display("FAIL flush_pc: got %h exp 0006", imem_addr); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", if_id_valid); end
    n_chk++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL flush_count: got %h exp 0002", fetch_count); end
  endtask

  task automatic test_halt();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(5);
    step(0, 1, 1, 1, 1, 0, 8'h10, 12'h000);
    n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b exp 1", halted); end
    n_chk++; if (imem_addr !== 16'h000A) begin n_fail++; $display("FAIL halt_pc: got %h exp 000a", imem_addr); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b exp 0", if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      step(0, i[0], ~i[0], i[1], 0, 0, 8'h20, 12'h100);
      n_chk++; if (imem_addr !== 16'h000A || halted !== 1'b1 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_frozen[%0d]: got pc=%h h=%b v=%b exp 000a/1/0", i, imem_addr, halted, if_id_valid); end
      n_chk++; if (fetch_count !== 16'd5 || if_id_instr !== 16'h5555) begin n_fail++; $display("FAIL halt_state[%0d]: got cnt=%h ins=%h exp 0005/5555", i, fetch_count, if_id_instr); end
    end
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    n_chk++; if (imem_addr !== 16'h0000 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h h=%b exp 0000/0", imem_addr, halted); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(1);
    step(0, 0, 1, 0, 0, 0, 8'h00, 12'hFFE);
    n_chk++; if (imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_jump: got %h exp fffe", imem_addr); end
    fetch_n(1);
    n_chk++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h exp 0000", imem_addr); end
    n_chk++; if (if_id_pc_plus2 !== 16'h0000 || if_id_instr !== imem_f(16'hFFFE)) begin n_fail++; $display("FAIL wrap_ifid: got %h/%h exp 0000/%h", if_id_pc_plus2, if_id_instr, imem_f(16'hFFFE)); end
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(1);
    step(0, 0, 1, 1, 0, 0, 8'h80, 12'h000);
    n_chk++; if (imem_addr !== 16'hFF02) begin n_fail++; $display("FAIL wrap_branch: got %h exp ff02", imem_addr); end
  endtask

  task automatic test_saturate();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(20);
    n_chk++; if (s_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_count: got %h exp f", s_cnt); end
    n_chk++; if (fetch_count !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %h exp 0014", fetch_count); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    fetch_n(3);
    step(1, 0, 1, 1, 0, 0, 8'h40, 12'h000);
    n_chk++; if (imem_addr !== 16'h0000 || if_id_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl: got pc=%h v=%b h=%b exp 0000/0/0", imem_addr, if_id_valid, halted); end
    n_chk++; if (if_id_instr !== 16'h0 || if_id_pc_plus2 !== 16'h0 || fetch_count !== 16'h0) begin n_fail++; $display("FAIL rstmid_regs: got %h/%h/%h exp 0/0/0", if_id_instr, if_id_pc_plus2, fetch_count); end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0, 8'h00, 12'h000);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           1'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
           8'($urandom), 12'($urandom));
      n_chk++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h exp %h", i, imem_addr, m_pc); end
      n_chk++; if (if_id_instr !== m_instr || if_id_pc_plus2 !== m_pp2) begin n_fail++; $display("FAIL rand_ifid[%0d]: got %h/%h exp %h/%h", i, if_id_instr, if_id_pc_plus2, m_instr, m_pp2); end
      n_chk++; if (if_id_valid !== m_valid || halted !== m_halted) begin n_fail++; $display("FAIL rand_flags[%0d]: got v=%b h=%b exp v=%b h=%b", i, if_id_valid, halted, m_valid, m_halted); end
      n_chk++; if (fetch_count !== m_cnt || s_cnt !== m_scnt) begin n_fail++; $display("FAIL rand_count[%0d]: got %h/%h exp %h/%h", i, fetch_count, s_cnt, m_cnt, m_scnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no end exp end");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; stall = 1'b0; pc_op = 1'b0; b_jmp = 1'b0; halt = 1'b0; if_flush = 1'b0;
    br_offset = 8'h00; jmp_offset = 12'h000;
    test_reset();
    test_fetch();
    test_redirect();
    test_stall();
    test_flush();
    test_halt();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor.
- Acts as the receiving end of the decode-stage control bundle: it consumes pc_op, b_jmp, halt and if_flush from the control unit, plus stall from the hazard logic.
- It owns the PC, drives the instruction-memory address and loads the IF/ID pipeline register.
- It also implements halt freeze and counts fetched instructions.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, fetched-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall: hold PC and IF/ID.
- pc_op  in  1  redirect PC this cycle (branch taken or jump).
- b_jmp  in  1  redirect type: 1 = branch (8-bit offset), 0 = jump (12-bit offset).
- halt  in  1  halt instruction decoded in ID.
- if_flush  in  1  invalidate the IF/ID contents loaded this cycle.
- br_offset  in  8  signed branch offset, in instruction words.
- jmp_offset  in  12  signed jump offset, in instruction words.
- imem_addr  out  ADDR_W  instruction-memory address; equals the PC.
- imem_data  in  INSTR_W  instruction word; combinational read of imem_addr.
- if_id_instr  out  INSTR_W  registered instruction.
- if_id_pc_plus2  out  ADDR_W  registered PC+2 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real instruction; 0 = bubble.
- halted  out  1  1 = core halted.
- fetch_count  out  CNT_W  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pc=RESET_PC, if_id_instr=0, if_id_pc_plus2=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
  - Reset overrides every other input, including when state=HALTED.
- States: RUN and HALTED.
  - RUN -> HALTED when halt=1 (and reset=0).
  - HALTED -> RUN only on reset.
  - halted = (state==HALTED), registered.
- Per-cycle priority in RUN, highest first:
  1. halt=1:
     - PC holds.
     - if_id_valid <= 0; other IF/ID fields hold.
     - Enter HALTED.
     - pc_op and stall are ignored that cycle.
  2. stall=1:
     - PC and all IF/ID fields hold.
     - pc_op and if_flush are ignored, because a stalled instruction in ID has not resolved.
  3. pc_op=1:
     - pc <= target.
     - if_id_valid <= 0 (redirect always squashes the wrong-path fetch, whether or not if_flush=1).
  4. Otherwise:
     - pc <= pc+2.
     - if_id_instr <= imem_data.
     - if_id_pc_plus2 <= pc+2.
     - if_id_valid <= ~if_flush.
- Target arithmetic:
  - Base = if_id_pc_plus2, the PC+2 of the instruction currently in ID.
  - b_jmp=1: target = base + (sext16(br_offset) << 1).
  - b_jmp=0: target = base + (sext16(jmp_offset) << 1).
  - All PC arithmetic is modulo 2^ADDR_W. PC 16'hFFFE + 2 = 16'h0000; no error is flagged.
- In HALTED:
  - pc, IF/ID and fetch_count are frozen.
  - if_id_valid=0.
  - All inputs except reset are ignored.
- imem_addr = pc, combinationally from the PC register; it is stable for the whole cycle.
- fetch_count:
  - Increments by 1 on each edge at which if_id_valid is written to 1.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Latency:
  - An instruction at address A appears on if_id_instr one cycle after imem_addr=A.
  - A redirect asserted in cycle N gives imem_addr=target in cycle N+1, with one bubble in IF/ID.
- if_flush with pc_op=0 and stall=0: PC advances normally; the loaded entry is marked invalid.

Decomposition:
- Shared package (proc_pkg) holds:
  - ADDR_W and INSTR_W.
  - RESET_PC.
  - Opcode constants: OP_HALT=4'b0000, OP_JMP=4'b0111, OP_BEQ=4'b0110, OP_BGT=4'b0100, OP_BLT=4'b0101.
  - Fetch state enum {RUN, HALTED}.
- One natural sub-module: pc_target_calc.
  - Combinational.
  - Inputs: base, b_jmp, br_offset, jmp_offset.
  - Output: target (sign-extend, shift, add).
- Top level holds the PC, the IF/ID register, the FSM and the counter.

Test Plan:
- Reset then 4 free-running cycles, imem returning 16'h1111/2222/3333/4444 -> imem_addr 0,2,4,6; if_id_instr follows one cycle later; if_id_pc_plus2 2,4,6,8; fetch_count=4.
- With if_id_pc_plus2=16'h0010: pc_op=1, b_jmp=1, br_offset=8'hFC -> next imem_addr=16'h0008, if_id_valid=0 for one cycle. Then pc_op=1, b_jmp=0, jmp_offset=12'h010 -> target 16'h0030.
- stall=1 for 3 cycles with pc_op=1 asserted concurrently -> pc and IF/ID unchanged, fetch_count unchanged; normal fetch resumes after stall drops.
- halt=1 at pc=16'h000A -> halted=1 next cycle, pc frozen at 16'h000A, if_id_valid=0; later pc_op/stall pulses have no effect; reset -> pc=0, halted=0.
- pc=16'hFFFE, no redirect -> next pc=16'h0000. Branch from base 16'h0002 with br_offset=8'h80 -> target 16'hFF02.
- Force fetch_count=16'hFFFE (or run a long loop) -> saturates at 16'hFFFF. Reset asserted mid-redirect -> pc=RESET_PC, all outputs at reset values.
